bldc_motor_ctrl: RTL and testbench
==================================

# bldc_motor_ctrl

Parametrised three-phase BLDC motor controller: the next-generation single-motor block that combines PWM generation, hall-based six-step commutation, per-phase dead-time insertion, and hall and quadrature-encoder position counting. Compared with the previous generation it adds:
- direction control, braking and coasting;
- hall fault detection;
- input synchronisation;
- signed, width-configurable counters.

One instance sits between the motor-control register file and the gate-driver pins for each motor.

## Interface
Parameters:
- DUTY_WIDTH, 10, duty-cycle and PWM counter width
- ENC_WIDTH, 16, encoder counter width
- HALL_CNT_WIDTH, 8, hall counter width
- DEAD_TIME, 4, minimum clk cycles between one gate of a phase turning off and the other turning on (range 1..255)

Ports:
- clk  in  1  system clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  1 = drive motor; 0 = coast (all gates off)
- duty_cycle  in  DUTY_WIDTH  requested duty
- dir  in  1  0 = forward table, 1 = reverse table
- brake  in  1  1 = all low-side gates on, all high-side gates off
- fault_clr  in  1  single-cycle pulse that clears hall_fault
- hall  in  3  raw hall sensors {C,B,A}, asynchronous
- enc  in  2  raw quadrature {B,A}, asynchronous
- phase_h  out  3  high-side gates {C,B,A}
- phase_l  out  3  low-side gates {C,B,A}
- hall_count  out  HALL_CNT_WIDTH  signed hall step count
- enc_count  out  ENC_WIDTH  signed encoder count
- hall_fault  out  1  sticky hall fault flag
- enc_err  out  1  one-cycle pulse on an illegal encoder transition

## Operation
- **Reset:** every output is 0. Synchronisers, the PWM counter, the latched duty and the dead-time counters are also 0.
- **Synchronisation:** hall and enc each pass through a 2-FF synchroniser. All downstream logic uses the synchronised values (hs, es) and their previous-cycle copies (hp, ep).
- **PWM counter (pc):**
  - Counts 0 .. 2^DUTY_WIDTH−2, then wraps to 0 (period 2^DUTY_WIDTH−1).
  - duty_cycle is latched only when pc == 0.
  - pwm_on = (pc < duty_latched).
  - Duty 0 gives pwm_on never; duty all-ones gives pwm_on always.
- **Hall sequence:** the forward order is 101→100→110→010→011→001→101.
- **Commutation, dir = 0:**
  - 101: A high, B low
  - 100: A high, C low
  - 110: B high, C low
  - 010: B high, A low
  - 011: C high, A low
  - 001: C high, B low
- **Commutation, dir = 1:** high and low roles are swapped for each state.
- **Gate requests:**
  - The high phase's H gate is requested as pwm_on.
  - The low phase's L gate is requested continuously.
  - Every other gate is off.
- **Request priority (highest first):**
  1. hall_fault or !enable: all requests off.
  2. brake: all L requested, all H off.
  3. Commutation table.
- **Dead time (per phase):**
  - A gate turns on only after the opposite gate of the same phase has been off for DEAD_TIME consecutive cycles.
  - Turn-off is immediate.
  - phase_h[i] & phase_l[i] is never 1.
  - Gate outputs are registered.
- **Hall fault:**
  - Set when hs is 000 or 111, or when hs changes to a state that is not adjacent in the sequence.
  - Detection is disarmed for the first 4 cycles after reset release.
  - Sticky. fault_clr clears it only if no fault condition exists in the same cycle; a fault condition wins.
- **Hall count:** updated when hs ≠ hp and both are valid and adjacent.
  - Forward step: +1.
  - Reverse step: −1.
  - The direction is taken from the sensor sequence, not from dir.
  - Two's-complement wrap. No count on a fault transition.
- **Encoder count (x4 decode on es vs ep):**
  - Sequence 00→01→11→10→00 is +1; the reverse sequence is −1.
  - Both bits changing: no count, and enc_err pulses for 1 cycle.
  - Two's-complement wrap.
- **Reset mid-operation:** all gates drop immediately (asynchronous) and the counts go to 0.

## Timing
- Hall or enc input change to the synchronised value: 2 cycles.
- Hall change to counter update and to gate turn-off: 3 cycles.
- Gate turn-on: 3 cycles + DEAD_TIME when the opposite gate was just on. When the opposite gate has been off ≥ DEAD_TIME cycles, there is no extra delay.
- Enc change to enc_count: 3 cycles. enc_err is asserted in the same cycle as the missed count.
- A duty change takes effect at the next pc == 0, then appears on the gates 1 cycle later.
- Brake, enable and fault transitions: gate turn-off is registered 1 cycle after the request; turn-on obeys dead time.

## Test plan
- **Forward commutation.** Setup: duty = 512, enable = 1, dir = 0, hall stepped 101→100→110→010→011→001.
  - Required: gate pairs (A_H/B_L, A_H/C_L, B_H/C_L, B_H/A_L, C_H/A_L, C_H/B_L) after 3 cycles each.
  - Required: hall_count = 6; pwm high for 512 of 1023 cycles.
- **Reverse and dir.**
  - Hall stepped backward 6 steps: hall_count = −6 (0xFA).
  - dir = 1 at hall 101: B_H pwm with A_L on.
  - Duty 0 and duty 1023 give 0% and 100% H on-time.
- **Dead time.** With DEAD_TIME = 4, toggle brake while A_H is on.
  - Required: A_L rises exactly 4 cycles after A_H falls.
  - Required: no cycle with both gates of a phase high.
- **Hall faults.** Apply hall = 111, then a 101→110 skip.
  - Required: hall_fault = 1, all gates 0, count unchanged.
  - fault_clr while hall = 111: flag stays 1.
  - fault_clr with valid hall: flag clears.
  - No fault within 4 cycles of reset.
- **Encoder.**
  - 1000 forward quadrature edges: enc_count = 1000.
  - 1001 reverse edges: enc_count = −1 (0xFFFF).
  - 00→11 step: enc_err one-cycle pulse, count unchanged.
  - Wrap 0x7FFF+1 = 0x8000.
- **Async reset mid-PWM.** Assert rst_n = 0 during A_H on.
  - Required: all outputs 0 with no clock edge needed.
  - Required: counts stay 0 after release until valid edges arrive.

Source files
------------

// File: rtl/bldc_motor_ctrl.sv
// Three-phase BLDC controller: PWM generation, hall six-step commutation, per-phase
// dead time, hall fault detection and signed hall / quadrature position counters.
module bldc_motor_ctrl #(
    parameter int DUTY_WIDTH     = 10,
    parameter int ENC_WIDTH      = 16,
    parameter int HALL_CNT_WIDTH = 8,
    parameter int DEAD_TIME      = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [DUTY_WIDTH-1:0]     duty_cycle,
    input  logic                      dir,
    input  logic                      brake,
    input  logic                      fault_clr,
    input  logic [2:0]                hall,
    input  logic [1:0]                enc,
    output logic [2:0]                phase_h,
    output logic [2:0]                phase_l,
    output logic [HALL_CNT_WIDTH-1:0] hall_count,
    output logic [ENC_WIDTH-1:0]      enc_count,
    output logic                      hall_fault,
    output logic                      enc_err
);
    localparam logic [DUTY_WIDTH-1:0] PC_LAST  = {{(DUTY_WIDTH-1){1'b1}}, 1'b0};
    localparam logic [7:0]            DT_READY = 8'(DEAD_TIME - 1);
    localparam logic [7:0]            DT_SAT   = 8'(DEAD_TIME);

    // Position of a hall code in the forward sequence; 7 marks 000/111.
    function automatic logic [2:0] hall_idx(input logic [2:0] h);
        case (h)
            3'b101:  return 3'd0;
            3'b100:  return 3'd1;
            3'b110:  return 3'd2;
            3'b010:  return 3'd3;
            3'b011:  return 3'd4;
            3'b001:  return 3'd5;
            default: return 3'd7;
        endcase
    endfunction

    function automatic logic [2:0] hall_succ(input logic [2:0] i);
        return (i == 3'd5) ? 3'd0 : i + 3'd1;
    endfunction

    function automatic logic [1:0] enc_idx(input logic [1:0] e);
        case (e)
            2'b00:   return 2'd0;
            2'b01:   return 2'd1;
            2'b11:   return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    logic [2:0] hall_s1, hs, hp;
    logic [1:0] enc_s1, es, ep;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hall_s1 <= '0;
            hs      <= '0;
            hp      <= '0;
            enc_s1  <= '0;
            es      <= '0;
            ep      <= '0;
        end else begin
            hall_s1 <= hall;
            hs      <= hall_s1;
            hp      <= hs;
            enc_s1  <= enc;
            es      <= enc_s1;
            ep      <= es;
        end
    end

    logic [2:0] hs_i, hp_i, arm_cnt;
    logic       hs_ok, hp_ok, hall_fwd, hall_rev, fault_cond, armed;
    logic [1:0] es_i, ep_i;
    logic       enc_fwd, enc_rev, enc_bad;

    assign hs_i       = hall_idx(hs);
    assign hp_i       = hall_idx(hp);
    assign hs_ok      = (hs_i != 3'd7);
    assign hp_ok      = (hp_i != 3'd7);
    assign hall_fwd   = hs_ok && hp_ok && (hs_i == hall_succ(hp_i));
    assign hall_rev   = hs_ok && hp_ok && (hp_i == hall_succ(hs_i));
    assign armed      = (arm_cnt == 3'd4);
    assign fault_cond = armed && (!hs_ok || ((hs != hp) && hp_ok && !hall_fwd && !hall_rev));

    assign es_i    = enc_idx(es);
    assign ep_i    = enc_idx(ep);
    assign enc_fwd = (es_i == ep_i + 2'd1);
    assign enc_rev = (ep_i == es_i + 2'd1);
    assign enc_bad = ((es ^ ep) == 2'b11);

    // Counters also wait for the arm window so the synchroniser leaving its
    // reset value is never mistaken for motion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arm_cnt    <= '0;
            hall_fault <= 1'b0;
            hall_count <= '0;
            enc_count  <= '0;
            enc_err    <= 1'b0;
        end else begin
            if (!armed)
                arm_cnt <= arm_cnt + 3'd1;
            if (fault_cond)
                hall_fault <= 1'b1;
            else if (fault_clr)
                hall_fault <= 1'b0;
            if (armed && hall_fwd)
                hall_count <= hall_count + HALL_CNT_WIDTH'(1);
            else if (armed && hall_rev)
                hall_count <= hall_count - HALL_CNT_WIDTH'(1);
            if (armed && enc_fwd)
                enc_count <= enc_count + ENC_WIDTH'(1);
            else if (armed && enc_rev)
                enc_count <= enc_count - ENC_WIDTH'(1);
            enc_err <= armed && enc_bad;
        end
    end

    logic [DUTY_WIDTH-1:0] pc, duty_l, duty_eff;
    logic                  pwm_on;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= '0;
            duty_l <= '0;
        end else begin
            pc <= (pc == PC_LAST) ? '0 : pc + DUTY_WIDTH'(1);
            if (pc == '0)
                duty_l <= duty_cycle;
        end
    end

    // The period-start cycle already uses the duty being latched.
    assign duty_eff = (pc == '0) ? duty_cycle : duty_l;
    assign pwm_on   = (pc < duty_eff);

    logic [2:0] tbl_h, tbl_l, req_h, req_l;

    always_comb begin
        tbl_h = '0;
        tbl_l = '0;
        case (hs)
            3'b101: begin tbl_h = 3'b001; tbl_l = 3'b010; end
            3'b100: begin tbl_h = 3'b001; tbl_l = 3'b100; end
            3'b110: begin tbl_h = 3'b010; tbl_l = 3'b100; end
            3'b010: begin tbl_h = 3'b010; tbl_l = 3'b001; end
            3'b011: begin tbl_h = 3'b100; tbl_l = 3'b001; end
            3'b001: begin tbl_h = 3'b100; tbl_l = 3'b010; end
            default: ;
        endcase
        req_h = '0;
        req_l = '0;
        // A fault seen this cycle blocks requests before the sticky flag lands.
        if (!(hall_fault || fault_cond || !enable)) begin
            if (brake) begin
                req_l = 3'b111;
            end else if (dir) begin
                req_h = tbl_l & {3{pwm_on}};
                req_l = tbl_h;
            end else begin
                req_h = tbl_h & {3{pwm_on}};
                req_l = tbl_l;
            end
        end
    end

    logic [2:0][7:0] h_off, l_off;
    logic [2:0]      h_nxt, l_nxt;

    always_comb begin
        h_nxt = '0;
        l_nxt = '0;
        for (int i = 0; i < 3; i++) begin
            h_nxt[i] = req_h[i] && !phase_l[i] && (l_off[i] >= DT_READY);
            l_nxt[i] = req_l[i] && !phase_h[i] && (h_off[i] >= DT_READY);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_off   <= '0;
            l_off   <= '0;
            phase_h <= '0;
            phase_l <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (phase_h[i])
                    h_off[i] <= '0;
                else if (h_off[i] < DT_SAT)
                    h_off[i] <= h_off[i] + 8'd1;
                if (phase_l[i])
                    l_off[i] <= '0;
                else if (l_off[i] < DT_SAT)
                    l_off[i] <= l_off[i] + 8'd1;
            end
            phase_h <= h_nxt;
            phase_l <= l_nxt;
        end
    end

endmodule

// File: tb/tb_bldc_motor_ctrl.sv
// Self-checking bench for bldc_motor_ctrl: randomized hall/encoder walks and duty
// values against a sequence-position model of the motor.
module tb_bldc_motor_ctrl;
    localparam int DW = 10;
    localparam int EW = 16;
    localparam int HW = 8;
    localparam int DT = 4;

    logic          clk = 1'b0, rst_n = 1'b0, enable = 1'b0, dir = 1'b0;
    logic          brake = 1'b0, fault_clr = 1'b0;
    logic [DW-1:0] duty_cycle = '0;
    logic [2:0]    hall = 3'b101;
    logic [1:0]    enc = 2'b00;
    logic [2:0]    phase_h, phase_l;
    logic [HW-1:0] hall_count;
    logic [EW-1:0] enc_count;
    logic          hall_fault, enc_err;

    int vectors = 0, miscompares = 0;

    // Reference model: positions in the forward hall / quadrature sequences.
    logic [2:0] hseq [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
    int         hi_ph [6] = '{0, 0, 1, 1, 2, 2};
    int         lo_ph [6] = '{1, 2, 2, 0, 0, 1};
    logic [1:0] gseq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    int hpos = 0, exp_hall = 0, epos = 0, exp_enc = 0;

    bldc_motor_ctrl #(.DUTY_WIDTH(DW), .ENC_WIDTH(EW), .HALL_CNT_WIDTH(HW), .DEAD_TIME(DT)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .duty_cycle(duty_cycle), .dir(dir),
        .brake(brake), .fault_clr(fault_clr), .hall(hall), .enc(enc),
        .phase_h(phase_h), .phase_l(phase_l), .hall_count(hall_count), .enc_count(enc_count),
        .hall_fault(hall_fault), .enc_err(enc_err)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] onehot(input int p);
        logic [2:0] v;
        v = '0;
        v[p] = 1'b1;
        return v;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic step_hall(input int d);
        hpos = (hpos + d + 6) % 6;
        exp_hall += d;
        hall = hseq[hpos];
    endtask

    task automatic step_enc(input int d);
        epos = (epos + d + 4) % 4;
        exp_enc += d;
        enc = gseq[epos];
    endtask

    task automatic test_reset();
        rst_n = 0; enable = 1; duty_cycle = 512; dir = 0; brake = 0; fault_clr = 0;
        hall = 3'b111; enc = 2'b00;
        #17;
        vectors++;
        if ({phase_h, phase_l, hall_count, enc_count, hall_fault, enc_err} !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got h=%b l=%b hc=%h ec=%h f=%b e=%b want all 0",
                     phase_h, phase_l, hall_count, enc_count, hall_fault, enc_err);
        end
        @(negedge clk); rst_n = 1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            vectors++;
            if (hall_fault !== 1'b0) begin
                miscompares++;
                $display("FAIL arm_window cycle %0d: got %b want 0", k, hall_fault);
            end
        end
        cycles(4);
        vectors++;
        if (hall_fault !== 1'b1) begin
            miscompares++;
            $display("FAIL fault_111_after_arm: got %b want 1", hall_fault);
        end
        hall = hseq[0]; hpos = 0;
        cycles(4);
        fault_clr = 1; @(negedge clk); fault_clr = 0;
        vectors++;
        if (hall_fault !== 1'b0) begin
            miscompares++;
            $display("FAIL clear_after_valid: got %b want 0", hall_fault);
        end
        vectors++;
        if (hall_count !== HW'(exp_hall) || enc_count !== EW'(exp_enc)) begin
            miscompares++;
            $display("FAIL counts_after_reset: got %h/%h want %h/%h",
                     hall_count, enc_count, HW'(exp_hall), EW'(exp_enc));
        end
    endtask

    task automatic test_forward_commutation();
        int n;
        cycles(20);
        for (int s = 0; s < 6; s++) begin
            step_hall(1);
            cycles(3);
            vectors++;
            if (phase_l !== onehot(lo_ph[hpos]) || (phase_h & ~onehot(hi_ph[hpos])) != 3'b000) begin
                miscompares++;
                $display("FAIL fwd_gates hall=%b: got h=%b l=%b want h<=%b l=%b",
                         hall, phase_h, phase_l, onehot(hi_ph[hpos]), onehot(lo_ph[hpos]));
            end
            vectors++;
            if (hall_count !== HW'(exp_hall)) begin
                miscompares++;
                $display("FAIL fwd_count: got %h want %h", hall_count, HW'(exp_hall));
            end
            cycles(15);
        end
        n = 0;
        repeat (1023) begin @(negedge clk); n += int'(phase_h[hi_ph[hpos]]); end
        vectors++;
        if (n != int'(duty_cycle)) begin
            miscompares++;
            $display("FAIL fwd_pwm_ontime: got %0d want %0d", n, duty_cycle);
        end
    endtask

    task automatic test_reverse_dir();
        int n;
        dir = 1;
        cycles(20);
        vectors++;
        if (phase_l !== onehot(hi_ph[hpos]) || (phase_h & ~onehot(lo_ph[hpos])) != 3'b000) begin
            miscompares++;
            $display("FAIL dir1_gates: got h=%b l=%b want h<=%b l=%b",
                     phase_h, phase_l, onehot(lo_ph[hpos]), onehot(hi_ph[hpos]));
        end
        n = 0;
        repeat (1023) begin @(negedge clk); n += int'(phase_h[lo_ph[hpos]]); end
        vectors++;
        if (n != int'(duty_cycle)) begin
            miscompares++;
            $display("FAIL dir1_pwm_ontime: got %0d want %0d", n, duty_cycle);
        end
        dir = 0;
        cycles(10);
        repeat (12) begin step_hall(-1); cycles(8); end
        vectors++;
        if (hall_count !== HW'(exp_hall)) begin
            miscompares++;
            $display("FAIL rev_count: got %h want %h", hall_count, HW'(exp_hall));
        end
        repeat (24) begin
            step_hall(($urandom_range(0, 1) == 1) ? 1 : -1);
            cycles(3);
            vectors++;
            if (hall_count !== HW'(exp_hall)) begin
                miscompares++;
                $display("FAIL walk_count: got %h want %h", hall_count, HW'(exp_hall));
            end
            cycles($urandom_range(1, 6));
        end
        while (hpos != 0) begin step_hall(1); cycles(4); end
        cycles(20);
        vectors++;
        if (hall_count !== HW'(exp_hall) || hall_fault !== 1'b0) begin
            miscompares++;
            $display("FAIL walk_end: got count %h fault %b want %h 0", hall_count, hall_fault, HW'(exp_hall));
        end
    endtask

    task automatic test_pwm_duty();
        int duties [4];
        int n;
        duties = '{0, 1023, int'($urandom_range(1, 1022)), int'($urandom_range(1, 1022))};
        foreach (duties[i]) begin
            duty_cycle = DW'(duties[i]);
            cycles(1100);
            n = 0;
            repeat (1023) begin @(negedge clk); n += int'(phase_h[0]); end
            vectors++;
            if (n != duties[i]) begin
                miscompares++;
                $display("FAIL pwm_ontime duty=%0d: got %0d want %0d", duties[i], n, duties[i]);
            end
        end
    endtask

    task automatic test_dead_time();
        int th, tl;
        logic overlap;
        duty_cycle = 1023;
        cycles(1100);
        vectors++;
        if (phase_h[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL ah_full_duty: got %b want 1", phase_h[0]);
        end
        brake = 1; th = -1; tl = -1; overlap = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (!phase_h[0] && th < 0) th = k;
            if (phase_l[0] && tl < 0) tl = k;
            overlap |= |(phase_h & phase_l);
        end
        vectors++;
        if (th != 1 || tl - th != DT) begin
            miscompares++;
            $display("FAIL brake_dead_time: got off@%0d on@%0d want off@1 gap %0d", th, tl, DT);
        end
        vectors++;
        if (phase_l !== 3'b111 || phase_h !== 3'b000) begin
            miscompares++;
            $display("FAIL brake_gates: got h=%b l=%b want 000 111", phase_h, phase_l);
        end
        brake = 0; th = -1; tl = -1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (!phase_l[0] && tl < 0) tl = k;
            if (phase_h[0] && th < 0) th = k;
            overlap |= |(phase_h & phase_l);
        end
        vectors++;
        if (tl != 1 || th - tl != DT) begin
            miscompares++;
            $display("FAIL release_dead_time: got off@%0d on@%0d want off@1 gap %0d", tl, th, DT);
        end
        vectors++;
        if (overlap !== 1'b0) begin
            miscompares++;
            $display("FAIL shoot_through: got %b want 0", overlap);
        end
        enable = 0;
        @(negedge clk);
        vectors++;
        if ((phase_h | phase_l) !== 3'b000) begin
            miscompares++;
            $display("FAIL coast: got h=%b l=%b want 000 000", phase_h, phase_l);
        end
        enable = 1;
        cycles(20);
    endtask

    task automatic test_hall_fault();
        hall = 3'b111;
        cycles(3);
        vectors++;
        if (hall_fault !== 1'b1 || (phase_h | phase_l) !== 3'b000 || hall_count !== HW'(exp_hall)) begin
            miscompares++;
            $display("FAIL fault_111: got f=%b h=%b l=%b cnt=%h want 1 000 000 %h",
                     hall_fault, phase_h, phase_l, hall_count, HW'(exp_hall));
        end
        fault_clr = 1; @(negedge clk); fault_clr = 0;
        vectors++;
        if (hall_fault !== 1'b1) begin
            miscompares++;
            $display("FAIL clr_during_111: got %b want 1", hall_fault);
        end
        hall = hseq[0]; hpos = 0;
        cycles(4);
        fault_clr = 1; @(negedge clk); fault_clr = 0;
        vectors++;
        if (hall_fault !== 1'b0) begin
            miscompares++;
            $display("FAIL clr_valid: got %b want 0", hall_fault);
        end
        cycles(20);
        vectors++;
        if (phase_h !== 3'b001 || phase_l !== 3'b010) begin
            miscompares++;
            $display("FAIL resume_gates: got h=%b l=%b want 001 010", phase_h, phase_l);
        end
        hpos = 2; hall = hseq[2];
        cycles(3);
        vectors++;
        if (hall_fault !== 1'b1 || (phase_h | phase_l) !== 3'b000 || hall_count !== HW'(exp_hall)) begin
            miscompares++;
            $display("FAIL fault_skip: got f=%b h=%b l=%b cnt=%h want 1 000 000 %h",
                     hall_fault, phase_h, phase_l, hall_count, HW'(exp_hall));
        end
        fault_clr = 1; @(negedge clk); fault_clr = 0;
        vectors++;
        if (hall_fault !== 1'b0) begin
            miscompares++;
            $display("FAIL clr_after_skip: got %b want 0", hall_fault);
        end
        step_hall(-1); cycles(4);
        step_hall(-1); cycles(4);
        vectors++;
        if (hall_count !== HW'(exp_hall)) begin
            miscompares++;
            $display("FAIL count_after_fault: got %h want %h", hall_count, HW'(exp_hall));
        end
    endtask

    task automatic test_encoder();
        int pulses, at, steps;
        logic [EW-1:0] held;
        repeat (1000) begin step_enc(1); cycles($urandom_range(1, 3)); end
        cycles(4);
        vectors++;
        if (enc_count !== EW'(exp_enc)) begin
            miscompares++;
            $display("FAIL enc_fwd_1000: got %h want %h", enc_count, EW'(exp_enc));
        end
        repeat (1001) begin step_enc(-1); cycles($urandom_range(1, 3)); end
        cycles(4);
        vectors++;
        if (enc_count !== EW'(exp_enc)) begin
            miscompares++;
            $display("FAIL enc_rev_1001: got %h want %h", enc_count, EW'(exp_enc));
        end
        held = enc_count;
        epos = (epos + 2) % 4;
        enc = gseq[epos];
        pulses = 0; at = -1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (enc_err) begin pulses++; if (at < 0) at = k; end
        end
        vectors++;
        if (pulses != 1 || at != 3) begin
            miscompares++;
            $display("FAIL enc_err_pulse: got %0d pulses at %0d want 1 at 3", pulses, at);
        end
        vectors++;
        if (enc_count !== EW'(exp_enc)) begin
            miscompares++;
            $display("FAIL enc_err_nocount: got %h want %h (before %h)", enc_count, EW'(exp_enc), held);
        end
        repeat (300) begin
            step_enc(($urandom_range(0, 1) == 1) ? 1 : -1);
            cycles($urandom_range(1, 2));
        end
        cycles(4);
        vectors++;
        if (enc_count !== EW'(exp_enc)) begin
            miscompares++;
            $display("FAIL enc_walk: got %h want %h", enc_count, EW'(exp_enc));
        end
        steps = (32767 - exp_enc) & 32'hFFFF;
        repeat (steps) begin step_enc(1); cycles(1); end
        cycles(4);
        vectors++;
        if (enc_count !== EW'(exp_enc)) begin
            miscompares++;
            $display("FAIL enc_max: got %h want %h", enc_count, EW'(exp_enc));
        end
        step_enc(1);
        cycles(4);
        vectors++;
        if (enc_count !== EW'(exp_enc)) begin
            miscompares++;
            $display("FAIL enc_wrap: got %h want %h", enc_count, EW'(exp_enc));
        end
    endtask

    task automatic test_async_reset();
        int w;
        w = 0;
        while (!phase_h[0] && w < 2000) begin @(negedge clk); w++; end
        vectors++;
        if (phase_h[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL ah_before_reset: got %b want 1", phase_h[0]);
        end
        #2 rst_n = 0;
        #1;
        vectors++;
        if ({phase_h, phase_l, hall_count, enc_count, hall_fault, enc_err} !== 32'h0) begin
            miscompares++;
            $display("FAIL async_reset: got h=%b l=%b hc=%h ec=%h f=%b e=%b want all 0",
                     phase_h, phase_l, hall_count, enc_count, hall_fault, enc_err);
        end
        epos = 0; enc = gseq[0]; exp_enc = 0; exp_hall = 0;
        @(negedge clk); @(negedge clk); rst_n = 1;
        cycles(10);
        vectors++;
        if (hall_count !== HW'(exp_hall) || enc_count !== EW'(exp_enc) || hall_fault !== 1'b0) begin
            miscompares++;
            $display("FAIL counts_after_release: got %h %h %b want %h %h 0",
                     hall_count, enc_count, hall_fault, HW'(exp_hall), EW'(exp_enc));
        end
        step_hall(1); cycles(3);
        vectors++;
        if (hall_count !== HW'(exp_hall)) begin
            miscompares++;
            $display("FAIL hall_after_release: got %h want %h", hall_count, HW'(exp_hall));
        end
        step_enc(1); cycles(3);
        vectors++;
        if (enc_count !== EW'(exp_enc)) begin
            miscompares++;
            $display("FAIL enc_after_release: got %h want %h", enc_count, EW'(exp_enc));
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_forward_commutation();
        test_reverse_dir();
        test_pwm_duty();
        test_dead_time();
        test_hall_fault();
        test_encoder();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
